data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the memory-stage data-memory interface. The memory stage initiates read/write requests; this block serves them.
- Backed by a word-addressed 16-bit data array. Serves one request at a time with a fixed, parameterised access latency.
- Returns read data and a completion response through a valid/ready handshake.
- Drives a stall indication so the pipeline can freeze the EX/MEM and MEM/WB buffers while an access is outstanding.

Parameters:
DEPTH, 1024, number of 16-bit words in the array; legal word addresses are 0..DEPTH-1
LAT, 2, cycles from request acceptance to response valid; legal range 1..15
AW, 10, index width; must equal ceil(log2(DEPTH))

Ports:
Clk  in  1  system clock; all state changes on the rising edge
Rst  in  1  reset, asynchronous, active-low (0 = reset)
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_read  in  1  read request (mem-read signal)
req_write  in  1  write request (mem-write signal)
req_addr  in  32  word address; also carries stack-pointer addresses for push/pop
req_wdata  in  16  write data (Rsrc value)
resp_valid  out  1  response present
resp_ready  in  1  initiator accepts the response
resp_rdata  out  16  read data; 0 for writes and errors
resp_err  out  1  access faulted: out of range or illegal command
stall  out  1  high whenever a request is accepted-but-not-completed or a response is pending

Behaviour:
- Reset (Rst=0, asynchronous):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, stall=0, latency counter=0.
  - Array contents are not cleared.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1, stall=0.
  - Acceptance occurs when req_valid=1 at a rising edge. The block latches addr, wdata, read and write.
  - After acceptance: if LAT=1, go to RESP; otherwise go to BUSY with counter=LAT-2.
  - req_valid with neither read nor write set is not accepted; it is ignored and req_ready stays 1.
- BUSY:
  - req_ready=0, stall=1.
  - Counter decrements each cycle. When the counter is 0, go to RESP on the next edge.
- Entry to RESP (the same edge as the transition):
  - Legal read: resp_rdata=mem[addr[AW-1:0]], resp_err=0.
  - Legal write: mem[addr[AW-1:0]] written with wdata, resp_rdata=0, resp_err=0.
  - Error case (addr >= DEPTH, compared across the full 32 bits, or read and write both set): no array access, resp_rdata=0, resp_err=1.
- RESP:
  - resp_valid=1, stall=1, req_ready=0.
  - resp_rdata and resp_err are held stable until the handshake completes.
  - On the edge where resp_ready=1: go to IDLE, deassert resp_valid, and clear resp_rdata and resp_err to 0.
  - There is no back-to-back accept on the same edge; the next request is accepted at the earliest one cycle after the response handshake.
- Latency: with acceptance at edge k, resp_valid is 1 in the cycle after edge k+LAT-1, i.e. LAT cycles after acceptance.
- Read-after-write to the same address in consecutive transactions returns the new data. The write commits before the next request can be accepted.
- Reset mid-operation (BUSY or RESP): the transaction is discarded. If the write had not yet reached RESP entry, the array is unchanged. The FSM returns to IDLE.
- Changes on req_* inputs after acceptance are ignored; only the latched copies are used.

Decomposition:
- Shared package (mem_pkg): FSM state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2) and the default DEPTH/LAT constants.
- One sub-module, data_mem_array: single-port synchronous-write/synchronous-read word array of DEPTH x 16. The responder contains the FSM, the latency counter, the range check and the output registers.

Test Plan:
- Reset, then LAT=2: write addr 5 data 16'hA5A5, resp_ready=1. Expect resp_valid exactly 2 cycles after acceptance, resp_err=0, resp_rdata=0. Then read addr 5: expect resp_rdata=16'hA5A5.
- resp_ready held 0 for 4 cycles during a read of addr 5. Expect resp_valid, resp_rdata=16'hA5A5 and stall=1 held steady; req_valid during this window is not accepted (req_ready=0).
- Write to addr 32'h0000_0400 with DEPTH=1024: expect resp_err=1, resp_rdata=0. A read of addr 0 afterward returns the prior value, showing no aliasing write.
- req_read=1 and req_write=1 together at addr 3: expect resp_err=1 and mem[3] unchanged. req_valid with both commands 0: expect no acceptance and stall=0.
- Pull Rst low while in BUSY on a write of 16'h1234 to addr 7. Expect resp_valid=0 and req_ready=1 immediately. mem[7] must retain its old value.
- LAT=1 build: back-to-back reads of addrs 1 and 2 with resp_ready=1. Expect responses 1 cycle after each acceptance and a one-cycle IDLE gap between transactions.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and default sizing.
package mem_pkg;

   localparam int DEPTH_DEF = 1024;
   localparam int LAT_DEF   = 2;
   localparam int CNT_W     = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the memory stage (master) and the data-memory responder (slave).
interface data_mem_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_read;
   logic        req_write;
   logic [31:0] req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_rdata;
   logic        resp_err;
   logic        stall;

   modport master (
      output req_valid, req_read, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err, stall
   );

   modport slave (
      input  req_valid, req_read, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err, stall
   );

endinterface

// File: rtl/data_mem_array.sv
// Single-port word array, DEPTH x 16, with synchronous write and registered read.
module data_mem_array #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   wdata,
   output logic [15:0]   rdata
);

   logic [15:0] mem [DEPTH];

   // The read register only moves when re is pulsed, so it holds through a stalled response.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one request at a time, waits LAT cycles, then returns data or an error.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int LAT   = LAT_DEF,
   parameter int AW    = 10
) (
   input  logic                 Clk,
   input  logic                 Rst,
   data_mem_responder_if.slave  bus
);

   localparam int LAT_M2 = (LAT > 1) ? LAT - 2 : 0;

   state_t             state;
   state_t             next_state;
   logic [CNT_W-1:0]   cnt;
   logic               lat_read;
   logic               lat_write;
   logic [31:0]        lat_addr;
   logic [15:0]        lat_wdata;
   logic               rd_flag;
   logic               err_q;
   logic               accept;
   logic               enter_resp;
   logic               cur_read;
   logic               cur_write;
   logic               cur_err;
   logic [31:0]        cur_addr;
   logic [15:0]        cur_wdata;
   logic               mem_we;
   logic               mem_re;
   logic [15:0]        arr_rdata;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state     = state;
      accept         = 1'b0;
      enter_resp     = 1'b0;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.stall      = 1'b1;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            bus.stall     = 1'b0;
            accept        = bus.req_valid && (bus.req_read || bus.req_write);
            if (accept) begin
               next_state = (LAT == 1) ? RESP : BUSY;
               enter_resp = (LAT == 1);
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               next_state = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            if (bus.resp_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // With LAT=1 the array is accessed on the acceptance edge, so the live bus feeds it directly.
   always_comb begin
      cur_read  = lat_read;
      cur_write = lat_write;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
      if (state == IDLE) begin
         cur_read  = bus.req_read;
         cur_write = bus.req_write;
         cur_addr  = bus.req_addr;
         cur_wdata = bus.req_wdata;
      end
      cur_err = (cur_addr >= 32'(DEPTH)) || (cur_read && cur_write);
      mem_we  = Rst && enter_resp && cur_write && !cur_err;
      mem_re  = Rst && enter_resp && cur_read && !cur_err;
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         cnt       <= '0;
         lat_read  <= 1'b0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rd_flag   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if (accept) begin
            lat_read  <= bus.req_read;
            lat_write <= bus.req_write;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            cnt       <= CNT_W'(LAT_M2);
         end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (enter_resp) begin
            rd_flag <= cur_read && !cur_err;
            err_q   <= cur_err;
         end else if (state == RESP && bus.resp_ready) begin
            rd_flag <= 1'b0;
            err_q   <= 1'b0;
         end
      end
   end

   data_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
      .clk   (Clk),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (cur_addr[AW-1:0]),
      .wdata (cur_wdata),
      .rdata (arr_rdata)
   );

   assign bus.resp_rdata = rd_flag ? arr_rdata : 16'h0000;
   assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LAT=2 instance with vector table, corner sequences and random traffic; LAT=1 instance for back-to-back reads.
module tb_data_mem_responder;

   localparam int LAT0 = 2;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [15:0] wd;
      int          hold;
      logic [15:0] exp_d;
      logic        exp_e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   int          total = 0;
   int          bad   = 0;
   logic [15:0] ref_mem [1024];
   bit          known   [1024];
   vec_t        vecs    [12];

   data_mem_responder_if b0 ();
   data_mem_responder_if b1 ();

   data_mem_responder #(.DEPTH(1024), .LAT(LAT0), .AW(10)) dut0 (
      .Clk (clk),
      .Rst (rst),
      .bus (b0)
   );

   data_mem_responder #(.DEPTH(1024), .LAT(1), .AW(10)) dut1 (
      .Clk (clk),
      .Rst (rst),
      .bus (b1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic model_write(input logic [31:0] addr, input logic [15:0] wd);
      ref_mem[addr[9:0]] = wd;
      known[addr[9:0]]   = 1'b1;
   endtask

   // Full LAT=2 transaction with an optional stalled response window of 'hold' cycles.
   task automatic txn(input logic rd, input logic wr, input logic [31:0] addr, input logic [15:0] wd,
                      input int hold, input logic [15:0] exp_d, input logic exp_e, input logic chk_d,
                      input string nm);
      int cyc;
      @(negedge clk);
      chk({nm, ".ready_before"}, b0.req_ready, 1);
      b0.req_valid  = 1'b1;
      b0.req_read   = rd;
      b0.req_write  = wr;
      b0.req_addr   = addr;
      b0.req_wdata  = wd;
      b0.resp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      b0.req_valid = 1'b0;
      b0.req_read  = 1'($urandom);
      b0.req_write = 1'($urandom);
      b0.req_addr  = $urandom;
      b0.req_wdata = 16'($urandom);
      cyc = 1;
      while (!b0.resp_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk({nm, ".latency"}, cyc, LAT0);
      chk({nm, ".stall"}, b0.stall, 1);
      chk({nm, ".ready_resp"}, b0.req_ready, 0);
      chk({nm, ".err"}, b0.resp_err, exp_e);
      if (chk_d) chk({nm, ".rdata"}, b0.resp_rdata, exp_d);
      for (int i = 0; i < hold; i++) begin
         b0.req_valid = 1'b1;
         b0.req_read  = 1'b1;
         b0.req_write = 1'b0;
         @(negedge clk);
         chk({nm, ".hold_valid"}, b0.resp_valid, 1);
         chk({nm, ".hold_ready"}, b0.req_ready, 0);
         chk({nm, ".hold_stall"}, b0.stall, 1);
         chk({nm, ".hold_err"}, b0.resp_err, exp_e);
         if (chk_d) chk({nm, ".hold_rdata"}, b0.resp_rdata, exp_d);
      end
      b0.req_valid  = 1'b0;
      b0.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b0.resp_ready = 1'b0;
      chk({nm, ".done_valid"}, b0.resp_valid, 0);
      chk({nm, ".done_rdata"}, b0.resp_rdata, 0);
      chk({nm, ".done_err"}, b0.resp_err, 0);
      chk({nm, ".done_stall"}, b0.stall, 0);
   endtask

   // LAT=1 transaction with resp_ready held high: response one cycle after acceptance.
   task automatic t1(input logic rd, input logic wr, input logic [31:0] addr, input logic [15:0] wd,
                     input logic [15:0] exp_d, input string nm);
      @(negedge clk);
      chk({nm, ".idle_ready"}, b1.req_ready, 1);
      chk({nm, ".idle_valid"}, b1.resp_valid, 0);
      b1.req_valid = 1'b1;
      b1.req_read  = rd;
      b1.req_write = wr;
      b1.req_addr  = addr;
      b1.req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      b1.req_valid = 1'b0;
      chk({nm, ".valid"}, b1.resp_valid, 1);
      chk({nm, ".rdata"}, b1.resp_rdata, exp_d);
      chk({nm, ".err"}, b1.resp_err, 0);
      @(posedge clk);
   endtask

   task automatic applyStimulus();
      logic        rd, wr, err, chk_d;
      logic [31:0] addr;
      logic [15:0] wd, exp_d;
      int          kind, sel;

      vecs[0]  = '{1'b0, 1'b1, 32'd5,          16'hA5A5, 0, 16'h0000, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 32'd5,          16'h0000, 0, 16'hA5A5, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'd5,          16'h0000, 4, 16'hA5A5, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 32'd0,          16'hBEEF, 1, 16'h0000, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 32'h0000_0400,  16'h1234, 2, 16'h0000, 1'b1};
      vecs[5]  = '{1'b1, 1'b0, 32'd0,          16'h0000, 0, 16'hBEEF, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 32'd3,          16'h1111, 0, 16'h0000, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 32'd3,          16'h2222, 1, 16'h0000, 1'b1};
      vecs[8]  = '{1'b1, 1'b0, 32'd3,          16'h0000, 0, 16'h1111, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 32'h8000_0005,  16'h0000, 0, 16'h0000, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 32'd1023,       16'h7E7E, 0, 16'h0000, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 32'd1023,       16'h0000, 3, 16'h7E7E, 1'b0};

      for (int i = 0; i < 12; i++) begin
         txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].hold,
             vecs[i].exp_d, vecs[i].exp_e, 1'b1, $sformatf("vec%0d", i));
         if (vecs[i].wr && !vecs[i].exp_e) model_write(vecs[i].addr, vecs[i].wd);
      end

      // A request with no command is never accepted.
      @(negedge clk);
      b0.req_valid = 1'b1;
      b0.req_read  = 1'b0;
      b0.req_write = 1'b0;
      b0.req_addr  = 32'd9;
      repeat (3) begin
         @(negedge clk);
         chk("nocmd.ready", b0.req_ready, 1);
         chk("nocmd.stall", b0.stall, 0);
         chk("nocmd.valid", b0.resp_valid, 0);
      end
      b0.req_valid = 1'b0;

      // Reset while BUSY on a write must leave the array untouched.
      txn(1'b0, 1'b1, 32'd7, 16'h0F0F, 0, 16'h0000, 1'b0, 1'b1, "pre7");
      model_write(32'd7, 16'h0F0F);
      @(negedge clk);
      b0.req_valid = 1'b1;
      b0.req_read  = 1'b0;
      b0.req_write = 1'b1;
      b0.req_addr  = 32'd7;
      b0.req_wdata = 16'h1234;
      @(posedge clk);
      @(negedge clk);
      b0.req_valid = 1'b0;
      chk("rst.busy_stall", b0.stall, 1);
      #1 rst = 1'b0;
      #1;
      chk("rst.valid", b0.resp_valid, 0);
      chk("rst.ready", b0.req_ready, 1);
      chk("rst.stall", b0.stall, 0);
      @(negedge clk);
      rst = 1'b1;
      txn(1'b1, 1'b0, 32'd7, 16'h0000, 0, 16'h0F0F, 1'b0, 1'b1, "post7");

      for (int n = 0; n < 60; n++) begin
         kind = $urandom_range(0, 9);
         rd   = (kind <= 3) || (kind >= 8);
         wr   = (kind >= 4) && (kind <= 8);
         sel  = $urandom_range(0, 9);
         if (sel < 8)       addr = 32'($urandom_range(0, 15));
         else if (sel == 8) addr = 32'd1024 + 32'($urandom_range(0, 100));
         else               addr = $urandom | 32'h8000_0000;
         wd    = 16'($urandom);
         err   = (rd && wr) || (addr >= 32'd1024);
         exp_d = (rd && !err) ? ref_mem[addr[9:0]] : 16'h0000;
         chk_d = !(rd && !err && !known[addr[9:0]]);
         txn(rd, wr, addr, wd, $urandom_range(0, 3), exp_d, err, chk_d, $sformatf("rnd%0d", n));
         if (wr && !err) model_write(addr, wd);
      end
   endtask

   task automatic checkOutput();
      t1(1'b0, 1'b1, 32'd1, 16'h1111, 16'h0000, "l1.w1");
      t1(1'b0, 1'b1, 32'd2, 16'h2222, 16'h0000, "l1.w2");
      t1(1'b1, 1'b0, 32'd1, 16'h0000, 16'h1111, "l1.r1");
      t1(1'b1, 1'b0, 32'd2, 16'h0000, 16'h2222, "l1.r2");
      @(negedge clk);
      chk("l1.gap_ready", b1.req_ready, 1);
   endtask

   initial begin
      rst = 1'b0;
      b0.req_valid = 1'b0; b0.req_read = 1'b0; b0.req_write = 1'b0;
      b0.req_addr = '0; b0.req_wdata = '0; b0.resp_ready = 1'b0;
      b1.req_valid = 1'b0; b1.req_read = 1'b0; b1.req_write = 1'b0;
      b1.req_addr = '0; b1.req_wdata = '0; b1.resp_ready = 1'b1;
      for (int i = 0; i < 1024; i++) known[i] = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset.ready", b0.req_ready, 1);
      chk("reset.valid", b0.resp_valid, 0);
      chk("reset.rdata", b0.resp_rdata, 0);
      chk("reset.err", b0.resp_err, 0);
      chk("reset.stall", b0.stall, 0);
      chk("reset.l1_ready", b1.req_ready, 1);
      rst = 1'b1;
      applyStimulus();
      checkOutput();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
